// File: rtl/lighting_pkg.sv
// rtl/lighting_pkg.sv - shared state codes and default timing constants for the lighting step controller
package lighting_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_MANUAL = 2'b01,
    ST_AUTO   = 2'b10,
    ST_HOLD   = 2'b11
  } state_t;

  localparam int DEB_CYCLES_DEF   = 4;
  localparam int DWELL_CYCLES_DEF = 8;
  localparam int CNT_W_DEF        = 16;

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - button synchroniser, debounce counter and clean-level edge detect
module button_debounce
  import lighting_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_clean,
  output logic rise,
  output logic fall
);

  // Last count value before the clean level is allowed to follow btn_s.
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             btn_s;
  logic [CNT_W-1:0] deb_cnt;
  logic             clean_q;
  logic             clean_d1;

  // Two-flop synchroniser: btn_raw is asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      btn_s <= sync1;
    end
  end

  // Debounce: the clean level only follows btn_s after DEB_CYCLES of disagreement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt <= '0;
      clean_q <= 1'b0;
    end else if (btn_s == clean_q) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      clean_q <= btn_s;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // One-cycle-delayed copy of the clean level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clean_d1 <= 1'b0;
    end else begin
      clean_d1 <= clean_q;
    end
  end

  assign btn_clean = clean_q;
  assign rise      = clean_q & ~clean_d1;
  assign fall      = ~clean_q & clean_d1;

endmodule

// File: rtl/lighting_step_ctrl.sv
// rtl/lighting_step_ctrl.sv - manual/auto step sequencer driving the lighting datapath advance input
module lighting_step_ctrl
  import lighting_pkg::*;
#(
  parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
  parameter int DWELL_CYCLES = DWELL_CYCLES_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_raw,
  input  logic       auto_en,
  output logic       step,
  output logic       btn_clean,
  output logic [1:0] state
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] dwell_q;
  logic [CNT_W-1:0] dwell_d;
  logic             step_q;
  logic             step_d;
  logic             dwell_wrap;
  logic             counting;
  logic             rise;
  logic             fall;

  button_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .btn_clean (btn_clean),
    .rise      (rise),
    .fall      (fall)
  );

  assign dwell_wrap = (dwell_q == DWELL_LAST);

  // Next state, step request and dwell update; leaving a state suppresses any coincident wrap step.
  always_comb begin
    state_d = state_q;
    step_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (auto_en) begin
          state_d = ST_AUTO;
        end else if (rise) begin
          state_d = ST_MANUAL;
          step_d  = 1'b1;
        end
      end
      ST_MANUAL: begin
        if (fall) begin
          state_d = ST_IDLE;
        end else if (dwell_wrap) begin
          step_d = 1'b1;
        end
      end
      ST_AUTO: begin
        if (!auto_en) begin
          state_d = ST_IDLE;
        end else if (rise) begin
          state_d = ST_HOLD;
        end else if (dwell_wrap) begin
          step_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!auto_en) begin
          state_d = ST_IDLE;
        end else if (rise) begin
          state_d = ST_AUTO;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Dwell runs only while staying in a stepping state; any entry starts it from zero.
    counting = (state_d == state_q) && ((state_q == ST_MANUAL) || (state_q == ST_AUTO));
    if (!counting) begin
      dwell_d = '0;
    end else if (dwell_wrap) begin
      dwell_d = '0;
    end else begin
      dwell_d = dwell_q + 1'b1;
    end
  end

  // State, dwell counter and registered step pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dwell_q <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      step_q  <= step_d;
    end
  end

  assign step  = step_q;
  assign state = state_q;

endmodule

// File: tb/tb_lighting_step_ctrl.sv
// tb/tb_lighting_step_ctrl.sv - directed vector and sequence bench for lighting_step_ctrl
module tb_lighting_step_ctrl;

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_MANUAL = 2'b01;
  localparam logic [1:0] S_AUTO   = 2'b10;
  localparam logic [1:0] S_HOLD   = 2'b11;

  typedef struct {
    logic       btn;
    logic       auto_en;
    logic       exp_step;
    logic       exp_clean;
    logic [1:0] exp_state;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       btn_raw;
  logic       auto_en;
  logic       step;
  logic       btn_clean;
  logic [1:0] state;

  int   n_tests;
  int   n_fail;
  vec_t vecs [64];

  lighting_step_ctrl #(
    .DEB_CYCLES   (4),
    .DWELL_CYCLES (8),
    .CNT_W        (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .auto_en   (auto_en),
    .step      (step),
    .btn_clean (btn_clean),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [1:0] act, input logic [1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Leaves the bench at a negedge with reset released; the next posedge is edge 0.
  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    btn_raw = 1'b0;
    auto_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Sample at the negedge before edge n (the value seen at edge n), then drive inputs for edge n.
  task automatic run_vecs(input string name, input int count);
    do_reset();
    for (int n = 0; n < count; n++) begin
      if (n > 0) tick();
      check({name, "_step"},  n, {1'b0, step},      {1'b0, vecs[n].exp_step});
      check({name, "_clean"}, n, {1'b0, btn_clean}, {1'b0, vecs[n].exp_clean});
      check({name, "_state"}, n, state,             vecs[n].exp_state);
      btn_raw = vecs[n].btn;
      auto_en = vecs[n].auto_en;
    end
  endtask

  initial begin
    int k;
    int steps_seen;
    logic done;

    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    btn_raw = 1'b0;
    auto_en = 1'b0;

    // Outputs while reset is held.
    #12;
    check("rst_step",  0, {1'b0, step},      2'b00);
    check("rst_clean", 0, {1'b0, btn_clean}, 2'b00);
    check("rst_state", 0, state,             S_IDLE);

    // 1. Bounce: raw toggles every 2 cycles for 20 cycles; nothing should get through.
    for (int n = 0; n < 30; n++) begin
      vecs[n].btn       = (n < 20) && (((n / 2) % 2) == 1);
      vecs[n].auto_en   = 1'b0;
      vecs[n].exp_step  = 1'b0;
      vecs[n].exp_clean = 1'b0;
      vecs[n].exp_state = S_IDLE;
    end
    run_vecs("bounce", 30);

    // 2. Manual hold: raw high for edges 0..29; steps seen at 7,15,23,31; clean 6..35; MANUAL 7..36.
    for (int n = 0; n < 40; n++) begin
      vecs[n].btn       = (n <= 29);
      vecs[n].auto_en   = 1'b0;
      vecs[n].exp_step  = (n == 7) || (n == 15) || (n == 23) || (n == 31);
      vecs[n].exp_clean = (n >= 6) && (n < 36);
      vecs[n].exp_state = ((n >= 7) && (n < 37)) ? S_MANUAL : S_IDLE;
    end
    run_vecs("manual", 40);

    // 3. Auto: AUTO seen from edge 1, steps seen at 9, 17, 25.
    for (int n = 0; n < 30; n++) begin
      vecs[n].btn       = 1'b0;
      vecs[n].auto_en   = 1'b1;
      vecs[n].exp_step  = (n == 9) || (n == 17) || (n == 25);
      vecs[n].exp_clean = 1'b0;
      vecs[n].exp_state = (n >= 1) ? S_AUTO : S_IDLE;
    end
    run_vecs("auto", 30);

    // 4. Pause and resume.
    do_reset();
    auto_en = 1'b1;
    repeat (12) tick();
    btn_raw = 1'b1;
    done = 1'b0;
    for (int c = 1; c <= 20 && !done; c++) begin
      tick();
      if (c >= 8) btn_raw = 1'b0;
      if (state == S_HOLD) done = 1'b1;
    end
    check("pause_enter_hold", 0, {1'b0, done}, 2'b01);
    btn_raw = 1'b0;
    steps_seen = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (step) steps_seen++;
      if (state != S_HOLD) done = 1'b0;
    end
    check("pause_no_step", 0, steps_seen[1:0], 2'b00);
    check("pause_stays_hold", 0, {1'b0, done}, 2'b01);
    btn_raw = 1'b1;
    done = 1'b0;
    for (int c = 1; c <= 20 && !done; c++) begin
      tick();
      if (c >= 8) btn_raw = 1'b0;
      if (state == S_AUTO) done = 1'b1;
    end
    check("resume_enter_auto", 0, {1'b0, done}, 2'b01);
    k = 0;
    done = 1'b0;
    for (int c = 1; c <= 20 && !done; c++) begin
      tick();
      if (c >= 8) btn_raw = 1'b0;
      if (step) begin
        k = c;
        done = 1'b1;
      end
    end
    check("resume_first_step_delay", 0, k[1:0] == 2'b00 && k == 8 ? 2'b01 : 2'b00, 2'b01);
    if (k != 8) $display("FAIL resume_delay_value: got %0d cycles, expected 8", k);
    btn_raw = 1'b0;

    // 5a. Rise and auto_en drop on the same edge while in AUTO: IDLE wins, no step.
    do_reset();
    auto_en = 1'b1;
    repeat (12) tick();
    btn_raw = 1'b1;
    repeat (6) tick();
    check("prio_clean_at_6", 0, {1'b0, btn_clean}, 2'b01);
    check("prio_auto_at_6", 0, state, S_AUTO);
    auto_en = 1'b0;
    tick();
    check("prio_idle_at_7", 0, state, S_IDLE);
    check("prio_step_at_7", 0, {1'b0, step}, 2'b00);
    steps_seen = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (step) steps_seen++;
    end
    check("prio_no_step_after", 0, steps_seen[1:0], 2'b00);
    btn_raw = 1'b0;

    // 5b. auto_en raised in MANUAL: held until release, then IDLE for one cycle, then AUTO.
    do_reset();
    btn_raw = 1'b1;
    repeat (10) tick();
    check("man_auto_in_manual", 0, state, S_MANUAL);
    auto_en = 1'b1;
    repeat (10) tick();
    check("man_auto_ignored", 0, state, S_MANUAL);
    btn_raw = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      tick();
      if (state != S_MANUAL) done = 1'b1;
    end
    check("man_auto_left_manual", 0, {1'b0, done}, 2'b01);
    check("man_auto_idle", 0, state, S_IDLE);
    tick();
    check("man_auto_to_auto", 0, state, S_AUTO);

    // 6. Reset asserted mid-cycle while step is high.
    do_reset();
    btn_raw = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      tick();
      if (step) done = 1'b1;
    end
    check("rst_mid_saw_step", 0, {1'b0, done}, 2'b01);
    #1;
    rst_n   = 1'b0;
    btn_raw = 1'b0;
    #1;
    check("rst_mid_step", 0, {1'b0, step}, 2'b00);
    check("rst_mid_state", 0, state, S_IDLE);
    check("rst_mid_clean", 0, {1'b0, btn_clean}, 2'b00);
    repeat (2) tick();
    rst_n = 1'b1;
    steps_seen = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (step) steps_seen++;
    end
    check("rst_release_no_step", 0, steps_seen[1:0], 2'b00);
    check("rst_release_idle", 0, state, S_IDLE);
    btn_raw = 1'b1;
    repeat (6) tick();
    check("rst_new_press_pre", 0, {1'b0, step}, 2'b00);
    tick();
    check("rst_new_press_step", 0, {1'b0, step}, 2'b01);
    btn_raw = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
